// File: rtl/event_timestamp_logger.sv
// Logs {event code, 64-bit time of day} for matching events into a FWFT FIFO; TS_LOG_OVF_COUNT_EN adds OverflowCount.
// Entry visible one cycle after the matching edge; when Full, a match is dropped unless a pop happens in the same cycle.
module event_timestamp_logger #(
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [7:0]            EventStream,
    input  logic [63:0]           TimeStamp,
    input  logic                  Enable,
    input  logic [7:0]            EventCode,
    input  logic                  RdEn,
    input  logic                  ClearOverflow,
    output logic [71:0]           RdData,
    output logic                  RdValid,
    output logic                  Empty,
    output logic                  Full,
    output logic [DEPTH_LOG2:0]   Count,
    output logic                  Overflow
`ifdef TS_LOG_OVF_COUNT_EN
    ,
    output logic [15:0]           OverflowCount
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef struct packed {
        logic [7:0]  code;
        logic [63:0] ts;
    } entry_t;

    entry_t              mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;

    logic reserved;
    logic match;
    logic pop;
    logic push;
    logic drop;

    // Control codes of the event stream are never logged, whatever EventCode says.
    assign reserved = (EventStream == 8'h00) || (EventStream == 8'h70) ||
                      (EventStream == 8'h71) || (EventStream == 8'h7D);
    assign match    = Enable && (EventStream == EventCode) && !reserved;

    assign Empty   = (wr_ptr == rd_ptr);
    assign Full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign Count   = wr_ptr - rd_ptr;
    assign RdValid = !Empty;

    assign pop  = RdEn && RdValid;
    assign push = match && (!Full || pop);
    assign drop = match && Full && !pop;

    assign RdData = RdValid ? mem[rd_ptr[DEPTH_LOG2-1:0]] : 72'h0;

    always_ff @(posedge Clock) begin
        if (push) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= '{code: EventStream, ts: TimeStamp};
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            Overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (drop) begin
                Overflow <= 1'b1;
            end else if (ClearOverflow) begin
                Overflow <= 1'b0;
            end
        end
    end

`ifdef TS_LOG_OVF_COUNT_EN
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            OverflowCount <= 16'h0;
        end else if (ClearOverflow) begin
            OverflowCount <= drop ? 16'h1 : 16'h0;
        end else if (drop && (OverflowCount != 16'hFFFF)) begin
            OverflowCount <= OverflowCount + 16'h1;
        end
    end
`endif

endmodule

// File: tb/tb_event_timestamp_logger.sv
// Directed and randomized bench for event_timestamp_logger against a queue-based model.
module tb_event_timestamp_logger;

    localparam int DEPTH_LOG2 = 5;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic                Clock;
    logic                Reset;
    logic [7:0]          EventStream;
    logic [63:0]         TimeStamp;
    logic                Enable;
    logic [7:0]          EventCode;
    logic                RdEn;
    logic                ClearOverflow;
    logic [71:0]         RdData;
    logic                RdValid;
    logic                Empty;
    logic                Full;
    logic [DEPTH_LOG2:0] Count;
    logic                Overflow;
`ifdef TS_LOG_OVF_COUNT_EN
    logic [15:0]         OverflowCount;
`endif

    event_timestamp_logger #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .EventStream(EventStream),
        .TimeStamp(TimeStamp),
        .Enable(Enable),
        .EventCode(EventCode),
        .RdEn(RdEn),
        .ClearOverflow(ClearOverflow),
        .RdData(RdData),
        .RdValid(RdValid),
        .Empty(Empty),
        .Full(Full),
        .Count(Count),
        .Overflow(Overflow)
`ifdef TS_LOG_OVF_COUNT_EN
        ,
        .OverflowCount(OverflowCount)
`endif
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    int tests = 0;
    int fails = 0;

    // Reference model: a queue of logged entries plus the sticky flag and drop counter.
    logic [71:0] q[$];
    bit          m_ovf;
    int          m_ovf_cnt;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_reserved(input logic [7:0] c);
        return (c == 8'h00) || (c == 8'h70) || (c == 8'h71) || (c == 8'h7D);
    endfunction

    task automatic check_outputs(input string tag);
        logic [71:0] exp_data;
        exp_data = (q.size() != 0) ? q[0] : 72'h0;
        chk({tag, ".rddata"}, RdData, exp_data);
        chk({tag, ".rdvalid"}, {71'h0, RdValid}, {71'h0, q.size() != 0});
        chk({tag, ".empty"}, {71'h0, Empty}, {71'h0, q.size() == 0});
        chk({tag, ".full"}, {71'h0, Full}, {71'h0, q.size() == DEPTH});
        chk({tag, ".count"}, {66'h0, Count}, 72'(q.size()));
        chk({tag, ".overflow"}, {71'h0, Overflow}, {71'h0, m_ovf});
`ifdef TS_LOG_OVF_COUNT_EN
        chk({tag, ".ovfcount"}, {56'h0, OverflowCount}, 72'(m_ovf_cnt));
`endif
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf     = 1'b0;
        m_ovf_cnt = 0;
    endtask

    // One clock: drive inputs, predict the effect of the edge, then compare after it.
    task automatic cycle(input string tag, input logic [7:0] ev, input logic [63:0] ts,
                         input logic en, input logic rd, input logic clr);
        bit pop, match, drop, push;
        EventStream   = ev;
        TimeStamp     = ts;
        Enable        = en;
        RdEn          = rd;
        ClearOverflow = clr;
        pop   = rd && (q.size() != 0);
        match = en && (ev == EventCode) && !is_reserved(ev);
        drop  = match && (q.size() == DEPTH) && !pop;
        push  = match && !drop;
        @(posedge Clock);
        #1;
        if (pop)  void'(q.pop_front());
        if (push) q.push_back({ev, ts});
        if (clr)  m_ovf = 1'b0;
        if (drop) m_ovf = 1'b1;
        if (clr)                          m_ovf_cnt = drop ? 1 : 0;
        else if (drop && m_ovf_cnt < 65535) m_ovf_cnt++;
        check_outputs(tag);
    endtask

    logic [7:0] rsv_list [4];
    logic [7:0] ev;
    logic [31:0] off;

    initial begin
        rsv_list[0] = 8'h00; rsv_list[1] = 8'h70; rsv_list[2] = 8'h71; rsv_list[3] = 8'h7D;
        Reset = 1'b1;
        EventStream = 8'h0; TimeStamp = 64'h0; Enable = 1'b0; EventCode = 8'h0;
        RdEn = 1'b0; ClearOverflow = 1'b0;
        model_reset();
        #1;
        check_outputs("reset");
        @(posedge Clock);
        @(posedge Clock);
        #1;
        Reset = 1'b0;

        // Single capture with the documented values.
        EventCode = 8'h2A;
        cycle("idle", 8'h11, 64'h0, 1'b1, 1'b0, 1'b0);
        cycle("single", 8'h2A, 64'h0000_1234_0000_0010, 1'b1, 1'b0, 1'b0);
        chk("single.literal", RdData, 72'h2A_0000_1234_0000_0010);
        chk("single.count1", {66'h0, Count}, 72'd1);
        cycle("single.pop", 8'h00, 64'h5, 1'b1, 1'b1, 1'b0);
        chk("single.empty", {71'h0, Empty}, 72'd1);
        cycle("rden_empty", 8'h00, 64'h6, 1'b1, 1'b1, 1'b0);

        // Reserved codes never match, even when selected.
        EventCode = 8'h7D;
        for (int i = 0; i < 12; i++)
            cycle("reserved", rsv_list[$urandom_range(0, 3)], 64'(i), 1'b1, 1'b0, 1'b0);
        EventCode = 8'h00;
        cycle("reserved00", 8'h00, 64'h77, 1'b1, 1'b0, 1'b0);
        chk("reserved.count0", {66'h0, Count}, 72'd0);

        // Enable low blocks capture.
        EventCode = 8'h55;
        cycle("disabled", 8'h55, 64'h99, 1'b0, 1'b0, 1'b0);

        // Fill with 33 back-to-back matches; the last one is dropped.
        for (int i = 1; i <= 33; i++)
            cycle("fill", 8'h55, {32'h1, 32'(i)}, 1'b1, 1'b0, 1'b0);
        chk("fill.full", {71'h0, Full}, 72'd1);
        chk("fill.count32", {66'h0, Count}, 72'd32);
        chk("fill.overflow", {71'h0, Overflow}, 72'd1);
        chk("fill.head", RdData, {8'h55, 32'h1, 32'd1});
`ifdef TS_LOG_OVF_COUNT_EN
        chk("fill.ovfcount", {56'h0, OverflowCount}, 72'd1);
`endif

        // Clear racing a drop: the set wins.
        cycle("clr_drop", 8'h55, {32'h1, 32'd40}, 1'b1, 1'b0, 1'b1);
        cycle("clr", 8'h12, 64'h0, 1'b1, 1'b0, 1'b1);
        chk("clr.overflow0", {71'h0, Overflow}, 72'd0);

        // Full with simultaneous read: no drop, new entry goes last.
        cycle("full_rw", 8'h55, {32'h1, 32'd34}, 1'b1, 1'b1, 1'b0);
        chk("full_rw.count", {66'h0, Count}, 72'd32);
        chk("full_rw.ovf", {71'h0, Overflow}, 72'd0);
        for (int i = 0; i < 32; i++)
            cycle("drain", 8'h00, 64'h0, 1'b1, 1'b1, 1'b0);

        // Wrap-around: interleaved pushes and pops with incrementing offsets.
        EventCode = 8'h3C;
        off = 32'd0;
        for (int i = 0; i < 100; i++) begin
            ev = ($urandom_range(0, 3) != 0) ? 8'h3C : 8'h3B;
            off++;
            cycle("wrap", ev, {32'h2, off}, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
            chk("wrap.count_le", {71'h0, Count <= 6'd32}, 72'd1);
        end

        // Randomized soak: codes changed between bursts, reserved bytes mixed in.
        for (int i = 0; i < 300; i++) begin
            if (i % 50 == 0) EventCode = ($urandom_range(0, 4) == 0) ? rsv_list[$urandom_range(0, 3)]
                                                                    : 8'($urandom_range(1, 255));
            case ($urandom_range(0, 3))
                0:       ev = rsv_list[$urandom_range(0, 3)];
                1:       ev = 8'($urandom);
                default: ev = EventCode;
            endcase
            cycle("rand", ev, {$urandom, $urandom}, 1'($urandom_range(0, 7) != 0),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < 33; i++)
            cycle("rand_drain", 8'h00, 64'h0, 1'b0, 1'b1, 1'b1);

        // Mid-stream reset with Count = 5 and Overflow set.
        EventCode = 8'h66;
        for (int i = 0; i < 33; i++)
            cycle("prefill", 8'h66, {32'h3, 32'(i)}, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 27; i++)
            cycle("predrain", 8'h00, 64'h0, 1'b1, 1'b1, 1'b0);
        chk("prereset.count5", {66'h0, Count}, 72'd5);
        chk("prereset.ovf", {71'h0, Overflow}, 72'd1);
        Reset = 1'b1;
        #1;
        model_reset();
        check_outputs("midreset");
        #1;
        Reset = 1'b0;
        cycle("resume", 8'h66, 64'hAAAA_BBBB_CCCC_DDDD, 1'b1, 1'b0, 1'b0);
        chk("resume.data", RdData, 72'h66_AAAA_BBBB_CCCC_DDDD);
        cycle("resume.pop", 8'h00, 64'h0, 1'b1, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
